// File: rtl/eth_loopback_bridge_if.sv
// AXI-Stream style payload bundle for eth_loopback_bridge.
// Master drives data/valid/last, slave drives ready.
interface eth_loopback_bridge_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/eth_loopback_bridge.sv
// Store-and-forward Ethernet loopback with MAC swap and frame counters.
// Optional ETH_MAC_FILTER_EN: accept only LOCAL_MAC/broadcast frames.
module eth_loopback_bridge #(
  parameter int          DATA_W     = 8,
  parameter int          DATA_DEPTH = 2048,
  parameter int          PKT_DEPTH  = 4,
  parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          header_valid,
  input  logic [47:0]   dest_mac,
  input  logic [47:0]   src_mac,
  input  logic [15:0]   ethertype,
  output logic          header_rd,
  eth_loopback_bridge_if.slave  s_axis,
  eth_loopback_bridge_if.master m_axis,
  output logic [111:0]  m_header,
  output logic          m_header_valid,
  input  logic          m_header_rd,
  output logic [15:0]   frames_fwd,
  output logic [15:0]   frames_drop
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int PW = $clog2(PKT_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DISCARD
  } state_t;

  state_t state, state_nx;

  logic [AW:0]     wr_ptr, commit_ptr, rd_ptr;
  logic [AW:0]     used;
  logic            full;
  logic [PW:0]     h_wr, h_rd, h_used;
  logic [PW+1:0]   h_occ;
  logic            h_full;
  logic [DATA_W:0] mem [DATA_DEPTH];
  logic [111:0]    hq [PKT_DEPTH];
  logic [111:0]    hdr_q;
  logic            push_q;
  logic            mac_ok, accept;
  logic [47:0]     src_out;
  logic            do_wr, do_commit, do_ovf, do_rej;
  logic            load;
  logic            out_valid, out_last;
  logic [DATA_W-1:0] out_data;

`ifdef ETH_MAC_FILTER_EN
  assign mac_ok  = (dest_mac == LOCAL_MAC) || (dest_mac == '1);
  assign src_out = LOCAL_MAC;
`else
  logic unused_cfg;
  assign unused_cfg = ^LOCAL_MAC;
  assign mac_ok     = 1'b1;
  assign src_out    = dest_mac;
`endif

  assign used   = wr_ptr - rd_ptr;
  assign full   = used[AW];
  assign h_used = h_wr - h_rd;
  // a commit whose header push is still in flight counts as occupied
  assign h_occ  = {1'b0, h_used} + (PW+2)'(push_q);
  assign h_full = |h_occ[PW+1:PW];
  assign accept = !h_full && mac_ok;

  assign s_axis.tready  = rst_n;
  assign m_header_valid = (h_wr != h_rd);
  assign m_header       = m_header_valid ? hq[h_rd[PW-1:0]] : '0;

  assign m_axis.tvalid = out_valid;
  assign m_axis.tlast  = out_last;
  assign m_axis.tdata  = out_data;

  assign load = (rd_ptr != commit_ptr) && (!out_valid || m_axis.tready);

  always_comb begin
    state_nx  = state;
    do_wr     = 1'b0;
    do_commit = 1'b0;
    do_ovf    = 1'b0;
    do_rej    = 1'b0;
    case (state)
      IDLE: begin
        if (header_valid) begin
          if (accept) begin
            state_nx = RECV;
          end else begin
            state_nx = DISCARD;
            do_rej   = 1'b1;
          end
        end
      end
      RECV: begin
        if (s_axis.tvalid) begin
          if (full) begin
            do_ovf   = 1'b1;
            state_nx = s_axis.tlast ? IDLE : DISCARD;
          end else begin
            do_wr = 1'b1;
            if (s_axis.tlast) begin
              do_commit = 1'b1;
              state_nx  = IDLE;
            end
          end
        end
      end
      DISCARD: begin
        if (s_axis.tvalid && s_axis.tlast) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= {s_axis.tlast, s_axis.tdata};
    if (push_q) hq[h_wr[PW-1:0]] <= hdr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      header_rd   <= 1'b0;
      hdr_q       <= '0;
      push_q      <= 1'b0;
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      rd_ptr      <= '0;
      h_wr        <= '0;
      h_rd        <= '0;
      frames_fwd  <= '0;
      frames_drop <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
    end else begin
      state     <= state_nx;
      header_rd <= (state == IDLE) && header_valid;
      push_q    <= do_commit;
      if ((state == IDLE) && header_valid)
        hdr_q <= {src_mac, src_out, ethertype};
      if (do_wr)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_ovf)
        wr_ptr <= commit_ptr;
      if (do_commit) begin
        commit_ptr <= wr_ptr + (AW+1)'(1);
        frames_fwd <= frames_fwd + 16'd1;
      end
      if (do_ovf || do_rej)
        frames_drop <= frames_drop + 16'd1;
      if (push_q)
        h_wr <= h_wr + (PW+1)'(1);
      if (m_header_rd && m_header_valid)
        h_rd <= h_rd + (PW+1)'(1);
      if (load) begin
        {out_last, out_data} <= mem[rd_ptr[AW-1:0]];
        rd_ptr    <= rd_ptr + (AW+1)'(1);
        out_valid <= 1'b1;
      end else if (m_axis.tready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_loopback_bridge.sv
// Directed/randomized bench for eth_loopback_bridge against a frame-queue model.
// Define ETH_MAC_FILTER_EN to also exercise the MAC filter.
module tb_eth_loopback_bridge;

  localparam int          DW   = 8;
  localparam int          DD   = 2048;
  localparam int          PD   = 4;
  localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         header_valid = 1'b0;
  logic [47:0]  dest_mac = '0;
  logic [47:0]  src_mac = '0;
  logic [15:0]  ethertype = '0;
  logic         header_rd;
  logic [111:0] m_header;
  logic         m_header_valid;
  logic         m_header_rd = 1'b0;
  logic [15:0]  frames_fwd, frames_drop;

  eth_loopback_bridge_if #(.DATA_W(DW)) s_axis ();
  eth_loopback_bridge_if #(.DATA_W(DW)) m_axis ();

  eth_loopback_bridge #(
    .DATA_W(DW), .DATA_DEPTH(DD), .PKT_DEPTH(PD), .LOCAL_MAC(LMAC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .header_valid(header_valid), .dest_mac(dest_mac),
    .src_mac(src_mac), .ethertype(ethertype),
    .header_rd(header_rd),
    .s_axis(s_axis), .m_axis(m_axis),
    .m_header(m_header), .m_header_valid(m_header_valid),
    .m_header_rd(m_header_rd),
    .frames_fwd(frames_fwd), .frames_drop(frames_drop)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_fwd = 0;
  int exp_drop = 0;
  int hrd_cnt = 0;
  int tlast_cnt = 0;
  logic [111:0] exp_hdrs[$];
  logic [DW:0]  exp_beats[$];

  always @(posedge clk) if (header_rd === 1'b1) hrd_cnt++;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit mac_pass(input logic [47:0] d);
`ifdef ETH_MAC_FILTER_EN
    return (d == LMAC) || (d == 48'hFFFF_FFFF_FFFF);
`else
    return (d === d);
`endif
  endfunction

  function automatic logic [47:0] out_src(input logic [47:0] d);
`ifdef ETH_MAC_FILTER_EN
    return LMAC;
`else
    return d;
`endif
  endfunction

  task automatic check_reset_outputs();
    check("rst_header_rd", header_rd, 0);
    check("rst_hdr_valid", m_header_valid, 0);
    check("rst_m_header", m_header, 0);
    check("rst_tvalid", m_axis.tvalid, 0);
    check("rst_tlast", m_axis.tlast, 0);
    check("rst_tdata", m_axis.tdata, 0);
    check("rst_fwd", frames_fwd, 0);
    check("rst_drop", frames_drop, 0);
  endtask

  task automatic send_frame(input logic [47:0] d, input logic [47:0] s,
                            input logic [15:0] et, input int len,
                            input int rst_at);
    logic [DW:0] fb[$];
    bit acc;
    bit hit_rst;
    int t;
    hit_rst = 0;
    @(negedge clk);
    dest_mac = d;
    src_mac = s;
    ethertype = et;
    header_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (header_rd !== 1'b1 && t < 20);
    check("header_rd_seen", header_rd, 1);
    header_valid = 1'b0;
    acc = mac_pass(d) && (exp_hdrs.size() < PD);
    if (acc && (len > DD - exp_beats.size())) acc = 0;
    if (!acc) exp_drop++;
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        s_axis.tvalid = 1'b0;
        #1 check("rst_tready", s_axis.tready, 0);
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        hit_rst = 1;
      end
      s_axis.tdata = DW'($urandom);
      s_axis.tvalid = 1'b1;
      s_axis.tlast = (i == len - 1);
      fb.push_back({s_axis.tlast, s_axis.tdata});
      @(negedge clk);
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
    if (hit_rst) begin
      exp_hdrs.delete();
      exp_beats.delete();
      exp_fwd = 0;
      exp_drop = 0;
    end else if (acc) begin
      exp_hdrs.push_back({s, out_src(d), et});
      foreach (fb[k]) exp_beats.push_back(fb[k]);
      exp_fwd++;
    end
  endtask

  task automatic drain(input int n, input bit rnd);
    int t;
    bit done;
    for (int f = 0; f < n; f++) begin
      t = 0;
      while (m_header_valid !== 1'b1 && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("hdr_valid_wait", m_header_valid, 1);
      if (exp_hdrs.size() > 0)
        check("m_header", m_header, exp_hdrs.pop_front());
      else
        check("unexpected_header", m_header_valid, 0);
      m_header_rd = 1'b1;
      @(negedge clk);
      m_header_rd = 1'b0;
      done = 0;
      t = 0;
      while (!done && t < 10000) begin
        m_axis.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m_axis.tvalid === 1'b1 && m_axis.tready) begin
          if (exp_beats.size() == 0)
            check("extra_beat", m_axis.tvalid, 0);
          else
            check("beat", {m_axis.tlast, m_axis.tdata}, exp_beats.pop_front());
          if (m_axis.tlast === 1'b1) begin
            done = 1;
            tlast_cnt++;
          end
        end
        @(negedge clk);
        t++;
      end
      m_axis.tready = 1'b0;
      check("frame_end", done, 1);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_fwd"}, frames_fwd, 128'(exp_fwd % 65536));
    check({tag, "_drop"}, frames_drop, 128'(exp_drop % 65536));
  endtask

  logic [47:0] dst_a;
  int tl0;

  initial begin
    s_axis.tdata = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
    m_axis.tready = 1'b0;
`ifdef ETH_MAC_FILTER_EN
    dst_a = LMAC;
`else
    dst_a = 48'hAAAA_AAAA_AAAA;
`endif
    repeat (3) @(negedge clk);
    check("rst_tready_init", s_axis.tready, 0);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single 64-beat frame with commit latency checks
    send_frame(dst_a, 48'h1111_1111_1111, 16'h0800, 64, -1);
    check("lat_hdr_t1", m_header_valid, 0);
    check("lat_tvalid_t1", m_axis.tvalid, 0);
    @(negedge clk);
    check("lat_hdr_t2", m_header_valid, 1);
    check("lat_tvalid_t2", m_axis.tvalid, 1);
`ifndef ETH_MAC_FILTER_EN
    check("swap_literal", m_header,
          {48'h1111_1111_1111, 48'hAAAA_AAAA_AAAA, 16'h0800});
`endif
    drain(1, 0);
    check("hrd_once", hrd_cnt, 1);
    check_counters("single");

    // five back-to-back frames, header queue holds four
    for (int i = 0; i < 5; i++)
      send_frame(dst_a, 48'h0000_0000_0100 + 48'(i), 16'(16'h0800 + i), 64, -1);
    repeat (3) @(negedge clk);
    check_counters("five");
    check("hrd_five", hrd_cnt, 6);
    drain(4, 0);
    repeat (3) @(negedge clk);
    check("five_no_extra", m_header_valid, 0);

    // payload overflow then a normal frame
    send_frame(dst_a, 48'h2222_2222_2222, 16'h86DD, DD + 10, -1);
    repeat (4) @(negedge clk);
    check("ovf_no_hdr", m_header_valid, 0);
    check("ovf_no_beat", m_axis.tvalid, 0);
    check_counters("ovf");
    send_frame(dst_a, 48'h3333_3333_3333, 16'h0806, 20, -1);
    drain(1, 0);
    check_counters("post_ovf");

    // random back-pressure over three frames
    tl0 = tlast_cnt;
    for (int i = 0; i < 3; i++)
      send_frame(dst_a, 48'h4444_0000_0000 + 48'(i), 16'h0800,
                 $urandom_range(1, 100), -1);
    drain(3, 1);
    check("rand_tlast", tlast_cnt - tl0, 3);
    repeat (3) @(negedge clk);
    check("rand_no_dup", m_axis.tvalid, 0);

`ifdef ETH_MAC_FILTER_EN
    send_frame(LMAC, 48'h5555_5555_5555, 16'h0800, 16, -1);
    send_frame(48'hFFFF_FFFF_FFFF, 48'h6666_6666_6666, 16'h0800, 16, -1);
    send_frame(48'h1234_1234_1234, 48'h7777_7777_7777, 16'h0800, 16, -1);
    drain(2, 0);
    repeat (3) @(negedge clk);
    check("filter_no_extra", m_header_valid, 0);
    check_counters("filter");
`endif

    // reset in the middle of a frame
    send_frame(dst_a, 48'h8888_8888_8888, 16'h0800, 60, 30);
    repeat (4) @(negedge clk);
    check("midrst_no_hdr", m_header_valid, 0);
    check_counters("midrst");
    send_frame(dst_a, 48'h9999_9999_9999, 16'h0800, 60, -1);
    drain(1, 0);
    check_counters("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
